// File: rtl/bnn_weight_streamer.sv
// Host-side weight streamer: buffers weight bytes in a small FIFO and sends each
// byte to the BNN loader as two strobed nibbles, low nibble first.
module bnn_weight_streamer #(
   parameter int NUM_NEURONS = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   input  logic       tgt_ena,
   output logic       load_en_o,
   output logic [3:0] nibble_o,
   output logic [4:0] neuron_idx,
   output logic       busy,
   output logic       done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [4:0]      r_neuron_idx;

   logic            w_empty;
   logic            w_full;
   logic [7:0]      w_head;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_last;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_head     = r_mem[r_rd_ptr];
   assign w_last     = (r_neuron_idx == 5'(NUM_NEURONS - 1));
   assign w_push     = s_valid && s_ready;
   assign neuron_idx = r_neuron_idx;

   // Outputs depend only on the registered state and the FIFO head, never on s_valid/s_data.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      load_en_o   = 1'b0;
      nibble_o    = 4'h0;
      busy        = 1'b0;
      done        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_LO;
               w_flush     = 1'b1;
            end
         end
         ST_LO: begin
            busy = 1'b1;
            if (!w_empty) begin
               load_en_o = 1'b1;
               nibble_o  = w_head[3:0];
               if (tgt_ena) begin
                  w_state_nxt = ST_HI;
               end
            end
         end
         ST_HI: begin
            // Head is valid here: bytes leave the FIFO only from this state.
            busy      = 1'b1;
            load_en_o = 1'b1;
            nibble_o  = w_head[7:4];
            if (tgt_ena) begin
               w_pop       = 1'b1;
               w_state_nxt = w_last ? ST_DONE : ST_LO;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_state_nxt = ST_LO;
               w_flush     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      s_ready = busy && !w_full;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_neuron_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_neuron_idx <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr     <= r_rd_ptr + AW'(1);
               r_neuron_idx <= r_neuron_idx + 5'd1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_data;
      end
   end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Self-checking bench for bnn_weight_streamer: a nibble scoreboard fed on byte
// acceptance and drained on each strobed transfer, plus directed checks.
module tb_bnn_weight_streamer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       tgt_ena;
   logic       load_en_o;
   logic [3:0] nibble_o;
   logic [4:0] neuron_idx;
   logic       busy;
   logic       done;

   int         n_checks;
   int         n_pass;
   logic [3:0] exp_q [$];

   bnn_weight_streamer #(
      .NUM_NEURONS(16),
      .FIFO_DEPTH (4)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .tgt_ena   (tgt_ena),
      .load_en_o (load_en_o),
      .nibble_o  (nibble_o),
      .neuron_idx(neuron_idx),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Scoreboard: bytes accepted push two nibbles, strobed transfers pop one.
   always @(negedge clk) begin
      if (!reset) begin
         check("strobe_vs_pending", 32'(load_en_o), 32'(exp_q.size() != 0));
         if (load_en_o && exp_q.size() != 0) begin
            check("nibble", 32'(nibble_o), 32'(exp_q[0]));
            if (tgt_ena) begin
               void'(exp_q.pop_front());
            end
         end
         if (s_valid && s_ready) begin
            exp_q.push_back(s_data[3:0]);
            exp_q.push_back(s_data[7:4]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("push_timeout", 32'(ok), 32'd1);
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !load_en_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("drain_timeout", 32'(ok), 32'd1);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int run;
      bit seen;
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      tgt_ena  = 1'b0;

      // Reset state
      #12;
      check("rst_load_en", 32'(load_en_o), 32'd0);
      check("rst_nibble", 32'(nibble_o), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_idx", 32'(neuron_idx), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      s_valid = 1'b1;
      s_data  = 8'h99;
      @(negedge clk);
      check("idle_s_ready", 32'(s_ready), 32'd0);
      tick();
      s_valid = 1'b0;

      // Full session: 16 bytes back-to-back, strobe high for 32 cycles
      tgt_ena = 1'b1;
      pulse_start();
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               push_byte(8'(i));
            end
         end
         begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (load_en_o) begin
                  seen = 1'b1;
                  break;
               end
            end
            run = 0;
            while (seen && load_en_o && run < 64) begin
               run++;
               @(negedge clk);
            end
            check("strobe_run", 32'(run), 32'd32);
         end
      join
      wait_drain();
      check("s1_done", 32'(done), 32'd1);
      check("s1_idx", 32'(neuron_idx), 32'd16);
      check("s1_busy", 32'(busy), 32'd0);
      s_valid = 1'b1;
      s_data  = 8'h10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("byte17_refused", 32'(s_ready), 32'd0);
      end
      tick();
      s_valid = 1'b0;

      // 0xA5 with tgt_ena 1,0,0,1
      tgt_ena = 1'b0;
      pulse_start();
      @(negedge clk);
      check("restart_idx", 32'(neuron_idx), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_done", 32'(done), 32'd0);
      tick();
      push_byte(8'hA5);
      tgt_ena = 1'b1;
      @(negedge clk);
      check("a5_lo", 32'(nibble_o), 32'h5);
      tick();
      tgt_ena = 1'b0;
      @(negedge clk);
      check("a5_hi_hold1", 32'(nibble_o), 32'hA);
      check("a5_idx_hold1", 32'(neuron_idx), 32'd0);
      tick();
      @(negedge clk);
      check("a5_hi_hold2", 32'(nibble_o), 32'hA);
      check("a5_idx_hold2", 32'(neuron_idx), 32'd0);
      tick();
      tgt_ena = 1'b1;
      @(negedge clk);
      check("a5_hi_xfer", 32'(nibble_o), 32'hA);
      check("a5_idx_pre", 32'(neuron_idx), 32'd0);
      tick();
      tgt_ena = 1'b0;
      @(negedge clk);
      check("a5_idx_post", 32'(neuron_idx), 32'd1);
      check("a5_strobe_off", 32'(load_en_o), 32'd0);
      tick();

      // Starvation after 0x3C
      tgt_ena = 1'b1;
      push_byte(8'h3C);
      wait_drain();
      check("starve_idx", 32'(neuron_idx), 32'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("starve_no_strobe", 32'(load_en_o), 32'd0);
         check("starve_nibble", 32'(nibble_o), 32'd0);
      end
      tick();
      push_byte(8'h77);
      @(negedge clk);
      check("resume_strobe", 32'(load_en_o), 32'd1);
      check("resume_nibble", 32'(nibble_o), 32'h7);
      wait_drain();
      check("resume_idx", 32'(neuron_idx), 32'd3);

      // Back-pressure: fill with tgt_ena low, no bypass on full+pop
      tgt_ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_byte(8'(8'h81 + i));
      end
      s_valid = 1'b1;
      s_data  = 8'h85;
      @(negedge clk);
      check("full_ready", 32'(s_ready), 32'd0);
      tick();
      tgt_ena = 1'b1;
      @(negedge clk);
      check("full_lo_ready", 32'(s_ready), 32'd0);
      tick();
      @(negedge clk);
      check("full_pop_no_bypass", 32'(s_ready), 32'd0);
      tick();
      @(negedge clk);
      check("ready_after_pop", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      wait_drain();
      check("bp_idx", 32'(neuron_idx), 32'd8);

      // Reset in HI after the low nibble of 0xF0
      tgt_ena = 1'b0;
      push_byte(8'hF0);
      tgt_ena = 1'b1;
      @(negedge clk);
      check("f0_lo", 32'(nibble_o), 32'h0);
      tick();
      tgt_ena = 1'b0;
      @(negedge clk);
      check("f0_hi", 32'(nibble_o), 32'hF);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_load_en", 32'(load_en_o), 32'd0);
      check("midrst_idx", 32'(neuron_idx), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_s_ready", 32'(s_ready), 32'd0);
      tick();
      reset   = 1'b0;
      tgt_ena = 1'b1;
      tick();
      pulse_start();
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd1);
      check("post_rst_empty", 32'(load_en_o), 32'd0);
      check("post_rst_ready", 32'(s_ready), 32'd1);
      tick();
      push_byte(8'h12);
      wait_drain();
      check("post_rst_idx", 32'(neuron_idx), 32'd1);

      // start in HI is ignored; start in DONE reopens the session
      tgt_ena = 1'b0;
      push_byte(8'h5A);
      tgt_ena = 1'b1;
      tick();
      tgt_ena = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      check("hi_start_nibble", 32'(nibble_o), 32'h5);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("hi_start_busy", 32'(busy), 32'd1);
      check("hi_start_hold", 32'(nibble_o), 32'h5);
      check("hi_start_idx", 32'(neuron_idx), 32'd1);
      tick();
      tgt_ena = 1'b1;
      wait_drain();
      check("hi_start_done_byte", 32'(neuron_idx), 32'd2);
      for (int i = 0; i < 14; i++) begin
         push_byte(8'(i * 17 + 3));
      end
      wait_drain();
      check("s2_done", 32'(done), 32'd1);
      check("s2_idx", 32'(neuron_idx), 32'd16);
      pulse_start();
      @(negedge clk);
      check("done_start_idx", 32'(neuron_idx), 32'd0);
      check("done_start_busy", 32'(busy), 32'd1);
      check("done_start_done", 32'(done), 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bnn_weight_streamer.md
Name: bnn_weight_streamer

Overview:
- Host-side writer for the BNN weight-load interface. It accepts 8-bit neuron weight bytes over a valid/ready stream and buffers them in a small FIFO.
- It serializes each byte into two 4-bit nibbles, low nibble first, driven with a load-enable strobe onto the loader pins (nibble on uio[7:4], strobe on uio[3]).
- It counts transferred neurons, stops after exactly NUM_NEURONS bytes and flags completion. The loader-side pointer is never driven out of range.

Parameters:
- NUM_NEURONS, 16, bytes (neurons) sent per session.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; opens a load session.
- s_valid  input  1  input byte valid.
- s_data  input  8  weight byte; bit i = weight for input i.
- s_ready  output  1  FIFO can accept a byte this cycle.
- tgt_ena  input  1  mirror of the loader's ena; a nibble counts as transferred only on an edge where load_en_o && tgt_ena.
- load_en_o  output  1  load strobe to the loader.
- nibble_o  output  4  nibble to the loader.
- neuron_idx  output  5  number of neurons fully transferred this session.
- busy  output  1  session active (LO or HI state).
- done  output  1  high in DONE state.

Behaviour:
- States: IDLE, LO, HI, DONE. Encoding is free. load_en_o, nibble_o, busy and done are decoded from the registered state and the FIFO head only; there is no combinational path from s_valid or s_data.
- Reset (async):
  - state=IDLE, FIFO empty, neuron_idx=0.
  - load_en_o=0, nibble_o=0, s_ready=0, busy=0, done=0.
- IDLE:
  - load_en_o=0, s_ready=0.
  - start → LO on the next edge; FIFO flushed and neuron_idx=0 on that edge.
- LO:
  - FIFO non-empty: load_en_o=1, nibble_o=head[3:0]. Edge with tgt_ena=1 → HI. tgt_ena=0 → hold LO with outputs unchanged.
  - FIFO empty: load_en_o=0, nibble_o=0, stay in LO. The loader's half-byte phase is untouched because no nibble is sent.
- HI:
  - load_en_o=1, nibble_o=head[7:4]. The head is always valid here because pops occur only in HI.
  - Edge with tgt_ena=1: pop the FIFO, neuron_idx+1. If the new count == NUM_NEURONS → DONE, else → LO.
  - tgt_ena=0 → hold HI.
- DONE:
  - load_en_o=0, s_ready=0, done=1, neuron_idx holds NUM_NEURONS.
  - start → LO with the FIFO flushed and neuron_idx=0.
- start while in LO or HI is ignored. Restarting mid-byte would desynchronize the loader's nibble phase.
- Consecutive bytes stream back-to-back: HI→LO with the FIFO still non-empty keeps load_en_o=1 continuously. One byte takes 2 cycles at tgt_ena=1.
- FIFO:
  - s_ready = busy && !full.
  - Push on s_valid && s_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - No bypass: a full FIFO with a concurrent pop still shows s_ready=0 that cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- Bytes offered in IDLE or DONE are not accepted (s_ready=0). The source must hold s_valid/s_data stable until accepted.
- The loader's neuron pointer clears only on its own reset. The system resets the loader before every session after the first. The streamer does not enforce this.
- Reset mid-session: immediate return to IDLE with all outputs at their reset values. A partially sent byte is discarded.

Test Plan:
- Reset, start, push 16 bytes 0x00..0x0F with tgt_ena=1 and s_valid always high:
  - nibble sequence 0,0,1,0,2,0,…,F,0 with load_en_o=1 continuously for 32 cycles.
  - done=1 and neuron_idx=16 afterwards.
  - a 17th byte is refused (s_ready=0).
- Push 0xA5, toggle tgt_ena 1,0,0,1:
  - nibble_o shows 5 then A; each is held through the tgt_ena=0 cycles.
  - neuron_idx increments only after the second tgt_ena=1 edge.
- Starve the FIFO after byte 0x3C (low nibble C, high nibble 3 sent):
  - load_en_o=0 in LO until the next byte arrives.
  - No strobe is issued with an empty FIFO.
- Hold tgt_ena=0 with 4 pending pushes: s_ready drops after 4 accepts. Release tgt_ena: the first pop re-asserts s_ready one cycle later.
- Assert reset in HI after the low nibble of 0xF0 was sent:
  - load_en_o=0 and neuron_idx=0 immediately; FIFO empty.
  - A new start re-sends from an empty FIFO.
- Pulse start in HI: ignored, the byte completes normally. Pulse start in DONE: neuron_idx clears to 0 and state=LO.
